adc_frame_packetizer: RTL and testbench

- Sits directly upstream of fifo_interface's TX side. Buffers 12-bit ADC samples in a small sample FIFO.
- Each sample is serialised into a 4-byte frame: sync, header, low byte, checksum.
- Each byte is handed to fifo_interface with a one-cycle strobe. The block waits for tx_ok/tx_err, and bounded retries recover FT245 back-pressure (nTXE high) without losing framing.

---
 rtl/adc_frame_packetizer.sv | 187 ++++++++++++++++++
 tb/tb_adc_frame_packetizer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packetizer.sv
// Buffers 12-bit ADC samples and serialises each into a 4-byte frame (sync, header, low, checksum).
// Each byte is strobed to the downstream FIFO interface and retried on error or timeout.
module adc_frame_packetizer #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     sample_valid_i,
  input  logic [11:0]              sample_i,
  output logic                     tx_data_rdy_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_ok_i,
  input  logic                     tx_err_i,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     overflow_o,
  output logic                     frame_done_o,
  output logic                     frame_drop_o,
  output logic                     busy_o
);

  // state | meaning
  // IDLE  | waiting for enable_i and a buffered sample; pops the head on start
  // LOAD  | latch the current frame byte onto tx_data_o, arm the attempt
  // SEND  | one-cycle tx_data_rdy_o strobe
  // WAIT  | waiting for tx_ok_i / tx_err_i / timeout
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = PW + 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [FW-1:0] DEPTH_F   = FW'(DEPTH);
  localparam logic [RW-1:0] MAX_RETRY_R = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT_CYC);

  state_t state_q, state_n;

  logic [11:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW-1:0] fill_q;
  logic          overflow_q;
  logic [3:0]    seq_q;
  logic [3:0]    frm_seq_q;
  logic [11:0]   frm_smp_q;
  logic [1:0]    idx_q;
  logic [RW-1:0] retry_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    tx_data_q;
  logic          done_q, drop_q;

  logic          pop, push;
  logic          load_byte, idx_inc, retry_inc, retry_clr, timer_load;
  logic          done_set, drop_set;
  logic [7:0]    byte_sel, b1, b2;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push = sample_valid_i && ((fill_q < DEPTH_F) || pop);

  assign b1 = {frm_seq_q, frm_smp_q[11:8]};
  assign b2 = frm_smp_q[7:0];

  always_comb begin
    byte_sel = SYNC_BYTE;
    case (idx_q)
      2'd0: byte_sel = SYNC_BYTE;
      2'd1: byte_sel = b1;
      2'd2: byte_sel = b2;
      2'd3: byte_sel = SYNC_BYTE ^ b1 ^ b2;
      default: byte_sel = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    pop        = 1'b0;
    load_byte  = 1'b0;
    idx_inc    = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    timer_load = 1'b0;
    done_set   = 1'b0;
    drop_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && (fill_q != '0)) begin
          pop     = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        load_byte = 1'b1;
        state_n   = SEND;
      end
      SEND: begin
        timer_load = 1'b1;
        state_n    = WAIT;
      end
      WAIT: begin
        if (tx_ok_i) begin
          retry_clr = 1'b1;
          if (idx_q == 2'd3) begin
            done_set = 1'b1;
            state_n  = IDLE;
          end else begin
            idx_inc = 1'b1;
            state_n = LOAD;
          end
        end else if (tx_err_i || (timer_q == '0)) begin
          if (retry_q < MAX_RETRY_R) begin
            retry_inc = 1'b1;
            state_n   = SEND;
          end else begin
            drop_set  = 1'b1;
            retry_clr = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= sample_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      seq_q      <= '0;
      frm_seq_q  <= '0;
      frm_smp_q  <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      done_q <= done_set;
      drop_q <= drop_set;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (sample_valid_i && !push) overflow_q <= 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PW'(1);
        seq_q     <= seq_q + 4'd1;
        frm_seq_q <= seq_q;
        frm_smp_q <= mem[rd_ptr_q];
        idx_q     <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
      if (retry_clr)      retry_q <= '0;
      else if (retry_inc) retry_q <= retry_q + RW'(1);
      // Down-counter per attempt; terminal count of zero signals the timeout.
      if (timer_load)                                timer_q <= TIMEOUT_T;
      else if ((state_q == WAIT) && (timer_q != '0)) timer_q <= timer_q - TW'(1);
      if (load_byte) tx_data_q <= byte_sel;
    end
  end

  assign tx_data_rdy_o = (state_q == SEND);
  assign tx_data_o     = tx_data_q;
  assign fill_o        = fill_q;
  assign overflow_o    = overflow_q;
  assign frame_done_o  = done_q;
  assign frame_drop_o  = drop_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_adc_frame_packetizer.sv
// Directed bench for adc_frame_packetizer: a background responder acks strobes,
// scenario tasks drive samples and compare logged bytes against hand-built frames.
module tb_adc_frame_packetizer;

  localparam int DEPTH = 8;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT_CYC = 1023;

  logic        clk_i;
  logic        reset_i;
  logic        enable_i;
  logic        sample_valid_i;
  logic [11:0] sample_i;
  logic        tx_data_rdy_o;
  logic [7:0]  tx_data_o;
  logic        tx_ok_i;
  logic        tx_err_i;
  logic [3:0]  fill_o;
  logic        overflow_o;
  logic        frame_done_o;
  logic        frame_drop_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] strobe_log[$];
  int         strobe_time[$];
  int         done_cnt = 0;
  int         drop_cnt = 0;
  int         cyc = 0;
  int         pend = 0;
  logic       pend_err = 1'b0;
  int         resp_left = -1;
  int         err_left = 0;
  logic [7:0] err_byte = 8'h00;

  adc_frame_packetizer #(
    .DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .MAX_RETRY(MAX_RETRY), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .sample_valid_i(sample_valid_i), .sample_i(sample_i),
    .tx_data_rdy_o(tx_data_rdy_o), .tx_data_o(tx_data_o),
    .tx_ok_i(tx_ok_i), .tx_err_i(tx_err_i),
    .fill_o(fill_o), .overflow_o(overflow_o),
    .frame_done_o(frame_done_o), .frame_drop_o(frame_drop_o), .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Responder: answers each strobe two cycles later with ok (or err when armed).
  initial begin
    tx_ok_i  = 1'b0;
    tx_err_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      tx_ok_i  = 1'b0;
      tx_err_i = 1'b0;
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          if (pend_err) tx_err_i = 1'b1;
          else          tx_ok_i  = 1'b1;
        end
      end
      if (frame_done_o === 1'b1) done_cnt++;
      if (frame_drop_o === 1'b1) drop_cnt++;
      if (tx_data_rdy_o === 1'b1) begin
        strobe_log.push_back(tx_data_o);
        strobe_time.push_back(cyc);
        if (resp_left != 0) begin
          if (resp_left > 0) resp_left--;
          pend     = 2;
          pend_err = (err_left > 0) && (tx_data_o == err_byte);
          if (pend_err) err_left--;
        end
      end
      cyc++;
    end
  end

  function automatic logic [31:0] frame_of(input logic [3:0] seq, input logic [11:0] s);
    logic [7:0] b0, b1, b2;
    b0 = 8'hA5;
    b1 = {seq, s[11:8]};
    b2 = s[7:0];
    return {b0, b1, b2, b0 ^ b1 ^ b2};
  endfunction

  function automatic logic [11:0] smp(input int i);
    logic [11:0] v;
    v = 12'(i * 179 + 496);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mon();
    strobe_log.delete();
    strobe_time.delete();
    done_cnt = 0;
    drop_cnt = 0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i   = 1'b0;
    pend      = 0;
    resp_left = -1;
    err_left  = 0;
    enable_i  = 1'b1;
    clear_mon();
  endtask

  task automatic push(input logic [11:0] s);
    sample_valid_i = 1'b1;
    sample_i       = s;
    tick();
    sample_valid_i = 1'b0;
  endtask

  task automatic wait_events(input int n_done, input int n_drop, input int budget, input string name);
    int k;
    k = 0;
    while ((done_cnt < n_done || drop_cnt < n_drop) && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (done_cnt < n_done || drop_cnt < n_drop) begin
      failures++;
      $display("FAIL %s wait expired: done=%0d drop=%0d required done=%0d drop=%0d",
               name, done_cnt, drop_cnt, n_done, n_drop);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fill_o, overflow_o, busy_o, tx_data_rdy_o, frame_done_o, frame_drop_o} !== 9'd0) begin
      failures++;
      $display("FAIL reset_flags got fill=%0d ovf=%b busy=%b rdy=%b done=%b drop=%b required all 0",
               fill_o, overflow_o, busy_o, tx_data_rdy_o, frame_done_o, frame_drop_o);
    end
    checks++;
    if (tx_data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got %h required 00", tx_data_o);
    end
  endtask

  task automatic test_single();
    logic [31:0] got;
    clear_mon();
    push(12'h3C7);
    checks++;
    if (fill_o !== 4'd1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL single_c1 got fill=%0d busy=%b required fill=1 busy=0", fill_o, busy_o);
    end
    tick();
    checks++;
    if (fill_o !== 4'd0 || busy_o !== 1'b1 || tx_data_rdy_o !== 1'b0) begin
      failures++;
      $display("FAIL single_c2 got fill=%0d busy=%b rdy=%b required fill=0 busy=1 rdy=0",
               fill_o, busy_o, tx_data_rdy_o);
    end
    tick();
    checks++;
    if (tx_data_rdy_o !== 1'b1 || tx_data_o !== 8'hA5) begin
      failures++;
      $display("FAIL single_c3 got rdy=%b data=%h required rdy=1 data=a5", tx_data_rdy_o, tx_data_o);
    end
    wait_events(1, 0, 100, "single_done");
    got = '0;
    if (strobe_log.size() == 4) got = {strobe_log[0], strobe_log[1], strobe_log[2], strobe_log[3]};
    checks++;
    if (strobe_log.size() != 4 || got !== 32'hA503C761) begin
      failures++;
      $display("FAIL single_bytes got n=%0d bytes=%h required n=4 bytes=a503c761", strobe_log.size(), got);
    end
    tick();
    tick();
    checks++;
    if (done_cnt != 1 || drop_cnt != 0 || fill_o !== 4'd0) begin
      failures++;
      $display("FAIL single_pulses got done=%0d drop=%0d fill=%0d required 1 0 0", done_cnt, drop_cnt, fill_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    int bad, gap_bad;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      int k;
      k = 0;
      while (fill_o == 4'd8 && k < 200) begin
        tick();
        k++;
      end
      push(smp(i));
    end
    wait_events(17, 0, 3000, "b2b_done");
    checks++;
    if (strobe_log.size() != 68) begin
      failures++;
      $display("FAIL b2b_count got %0d strobes required 68", strobe_log.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 17; i++) begin
        got = {strobe_log[4*i], strobe_log[4*i+1], strobe_log[4*i+2], strobe_log[4*i+3]};
        exp = frame_of(4'(i), smp(i));
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL b2b_frame%0d got %h required %h", i, got, exp);
        end
      end
      gap_bad = 0;
      for (int i = 1; i < 17; i++)
        if (strobe_time[4*i] - strobe_time[4*i-1] != 5) gap_bad++;
      for (int i = 0; i < 17; i++)
        for (int j = 1; j < 4; j++)
          if (strobe_time[4*i+j] - strobe_time[4*i+j-1] != 4) bad++;
      checks++;
      if (gap_bad != 0 || bad != 0) begin
        failures++;
        $display("FAIL b2b_timing got %0d frame gaps and %0d byte gaps off required 0 (5 and 4 cycles)",
                 gap_bad, bad);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] got, exp;
    do_reset();
    enable_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(smp(100 + i));
    checks++;
    if (fill_o !== 4'd8 || overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_full got fill=%0d ovf=%b required fill=8 ovf=0", fill_o, overflow_o);
    end
    push(12'hFFF);
    push(12'hEEE);
    checks++;
    if (fill_o !== 4'd8 || overflow_o !== 1'b1 || busy_o !== 1'b0 || strobe_log.size() != 0) begin
      failures++;
      $display("FAIL ovf_drop got fill=%0d ovf=%b busy=%b strobes=%0d required 8 1 0 0",
               fill_o, overflow_o, busy_o, strobe_log.size());
    end
    enable_i = 1'b1;
    wait_events(DEPTH, 0, 2000, "ovf_drain");
    for (int k = 0; k < 40; k++) tick();
    checks++;
    if (done_cnt != DEPTH || fill_o !== 4'd0 || overflow_o !== 1'b1 || strobe_log.size() != 4*DEPTH) begin
      failures++;
      $display("FAIL ovf_after got done=%0d fill=%0d ovf=%b strobes=%0d required 8 0 1 32",
               done_cnt, fill_o, overflow_o, strobe_log.size());
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        got = {strobe_log[4*i], strobe_log[4*i+1], strobe_log[4*i+2], strobe_log[4*i+3]};
        exp = frame_of(4'(i), smp(100 + i));
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL ovf_frame%0d got %h required %h", i, got, exp);
        end
      end
    end
  endtask

  task automatic test_retry();
    logic [47:0] got;
    do_reset();
    err_byte = 8'hC7;
    err_left = 2;
    push(12'h3C7);
    wait_events(1, 0, 200, "retry_done");
    tick();
    got = '0;
    if (strobe_log.size() == 6)
      got = {strobe_log[0], strobe_log[1], strobe_log[2], strobe_log[3], strobe_log[4], strobe_log[5]};
    checks++;
    if (strobe_log.size() != 6 || got !== 48'hA503C7C7C761) begin
      failures++;
      $display("FAIL retry_bytes got n=%0d bytes=%h required n=6 bytes=a503c7c7c761", strobe_log.size(), got);
    end
    checks++;
    if (drop_cnt != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL retry_pulses got done=%0d drop=%0d required 1 0", done_cnt, drop_cnt);
    end
  endtask

  task automatic test_timeout();
    int bad;
    logic [31:0] got;
    do_reset();
    resp_left = 0;
    push(12'h0AB);
    wait_events(0, 1, 6000, "timeout_drop");
    tick();
    checks++;
    if (strobe_log.size() != MAX_RETRY + 1 || done_cnt != 0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_strobes got n=%0d done=%0d busy=%b required n=%0d done=0 busy=0",
               strobe_log.size(), done_cnt, busy_o, MAX_RETRY + 1);
    end else begin
      bad = 0;
      for (int i = 0; i <= MAX_RETRY; i++) if (strobe_log[i] !== 8'hA5) bad++;
      for (int i = 1; i <= MAX_RETRY; i++)
        if (strobe_time[i] - strobe_time[i-1] != TIMEOUT_CYC + 2) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL timeout_b0 got %0d bad strobes/gaps required 0 (all a5, gap %0d)", bad, TIMEOUT_CYC + 2);
      end
    end
    clear_mon();
    resp_left = -1;
    push(12'h0CD);
    wait_events(1, 0, 200, "timeout_next");
    got = '0;
    if (strobe_log.size() == 4) got = {strobe_log[0], strobe_log[1], strobe_log[2], strobe_log[3]};
    checks++;
    if (got !== frame_of(4'd1, 12'h0CD)) begin
      failures++;
      $display("FAIL timeout_seq got %h required %h", got, frame_of(4'd1, 12'h0CD));
    end
  endtask

  task automatic test_reset_mid();
    int k, n;
    logic [31:0] got;
    do_reset();
    resp_left = 1;
    push(12'h111);
    push(12'h222);
    k = 0;
    while (strobe_log.size() < 2 && k < 100) begin
      tick();
      k++;
    end
    tick();
    checks++;
    if (strobe_log.size() != 2 || busy_o !== 1'b1 || tx_data_o !== 8'h01) begin
      failures++;
      $display("FAIL mid_wait got strobes=%0d busy=%b data=%h required 2 1 01", strobe_log.size(), busy_o, tx_data_o);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    pend = 0;
    checks++;
    if (busy_o !== 1'b0 || fill_o !== 4'd0 || tx_data_rdy_o !== 1'b0 || tx_data_o !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset got busy=%b fill=%0d rdy=%b data=%h required 0 0 0 00",
               busy_o, fill_o, tx_data_rdy_o, tx_data_o);
    end
    n = strobe_log.size();
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (strobe_log.size() != n || done_cnt != 0 || drop_cnt != 0) begin
      failures++;
      $display("FAIL mid_quiet got strobes=%0d done=%0d drop=%0d required %0d 0 0",
               strobe_log.size(), done_cnt, drop_cnt, n);
    end
    clear_mon();
    resp_left = -1;
    push(12'h5A1);
    wait_events(1, 0, 200, "mid_restart");
    got = '0;
    if (strobe_log.size() == 4) got = {strobe_log[0], strobe_log[1], strobe_log[2], strobe_log[3]};
    checks++;
    if (got !== frame_of(4'd0, 12'h5A1)) begin
      failures++;
      $display("FAIL mid_seq got %h required %h", got, frame_of(4'd0, 12'h5A1));
    end
  endtask

  initial begin
    reset_i        = 1'b1;
    enable_i       = 1'b1;
    sample_valid_i = 1'b0;
    sample_i       = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_retry();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
